fb_strip_writer: RTL and testbench

//  Write-side producer for the ping-pong strip frame buffer. Accepts an RGB888 pixel stream
//  (valid/ready), converts it to RGB565 and emits rgb_en/rgb_data strips of STRIP_PIXELS words.

---
 rtl/fb_strip_writer.sv | 181 ++++++++++++++++++
 tb/tb_fb_strip_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_strip_writer.sv
// Write-side producer for the ping-pong strip frame buffer: RGB888 stream in, RGB565 strips out,
// with one credit per strip buffer returned by the read side through a toggle synchroniser.
module fb_strip_writer #(
    parameter int unsigned COLS           = 240,
    parameter int unsigned ROWS_PER_STRIP = 8,
    parameter int unsigned STRIPS         = 40,
    parameter int unsigned NUM_BUFS       = 2
) (
    input  logic        wclk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        in_valid,
    input  logic [23:0] in_data,
    output logic        in_ready,
    input  logic        rd_done_tgl,
    output logic        rgb_en,
    output logic [15:0] rgb_data,
    output logic [7:0]  col_cnt,
    output logic [7:0]  row_cnt,
    output logic [5:0]  strip_cnt,
    output logic        strip_done,
    output logic        frame_done,
    output logic        busy,
    output logic        credit_err
);

    localparam int unsigned STRIP_PIXELS = COLS * ROWS_PER_STRIP;
    localparam int unsigned PIX_W        = $clog2(STRIP_PIXELS);
    localparam int unsigned CRED_W       = $clog2(NUM_BUFS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitCred,
        StStream,
        StStripEnd,
        StFrameEnd
    } state_e;

    state_e             r_state, w_state_d;
    logic               r_tgl_s1, r_tgl_s2, r_tgl_s3;
    logic [CRED_W-1:0]  r_credits;
    logic               r_credit_err;
    logic [PIX_W-1:0]   r_pix;
    logic [7:0]         r_col, r_row;
    logic [5:0]         r_strip;
    logic               r_rgb_en, r_strip_done, r_frame_done;
    logic [15:0]        r_rgb_data;
    logic [7:0]         r_col_o, r_row_o;
    logic [5:0]         r_strip_o;

    logic w_in_ready, w_accept, w_ret, w_consume, w_last_pix, w_last_col, w_last_strip;
    logic w_unused;

    assign w_in_ready   = (r_state == StStream);
    assign w_accept     = in_valid && w_in_ready;
    assign w_ret        = r_tgl_s2 ^ r_tgl_s3;
    assign w_consume    = (r_state == StWaitCred) && (r_credits != '0);
    assign w_last_pix   = (r_pix == PIX_W'(STRIP_PIXELS - 1));
    assign w_last_col   = (r_col == 8'(COLS - 1));
    assign w_last_strip = (r_strip == 6'(STRIPS - 1));
    assign w_unused     = ^{in_data[18:16], in_data[9:8], in_data[2:0]};

    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n) begin
            r_tgl_s1     <= 1'b0;
            r_tgl_s2     <= 1'b0;
            r_tgl_s3     <= 1'b0;
            r_credits    <= CRED_W'(NUM_BUFS);
            r_credit_err <= 1'b0;
        end else begin
            r_tgl_s1 <= rd_done_tgl;
            r_tgl_s2 <= r_tgl_s1;
            r_tgl_s3 <= r_tgl_s2;
            // A return coinciding with a consume nets to zero and cannot overflow.
            if (w_ret && !w_consume) begin
                if (r_credits == CRED_W'(NUM_BUFS)) begin
                    r_credit_err <= 1'b1;
                end else begin
                    r_credits <= r_credits + 1'b1;
                end
            end else if (!w_ret && w_consume) begin
                r_credits <= r_credits - 1'b1;
            end
        end
    end

    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:     if (frame_start) w_state_d = StWaitCred;
            StWaitCred: if (r_credits != '0) w_state_d = StStream;
            StStream:   if (w_accept && w_last_pix) w_state_d = StStripEnd;
            StStripEnd: w_state_d = w_last_strip ? StFrameEnd : StWaitCred;
            StFrameEnd: w_state_d = StIdle;
            default:    w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_strip <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (frame_start) begin
                        r_pix   <= '0;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_strip <= '0;
                    end
                end
                StStream: begin
                    if (w_accept) begin
                        r_pix <= w_last_pix ? '0 : r_pix + 1'b1;
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                StStripEnd: begin
                    if (!w_last_strip) begin
                        r_strip <= r_strip + 1'b1;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_pix   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Word, position and strobe are registered together; done pulses land after the last strobe.
    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb_en     <= 1'b0;
            r_rgb_data   <= '0;
            r_col_o      <= '0;
            r_row_o      <= '0;
            r_strip_o    <= '0;
            r_strip_done <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rgb_en     <= w_accept;
            r_strip_done <= (r_state == StStripEnd);
            r_frame_done <= (r_state == StFrameEnd);
            if (w_accept) begin
                r_rgb_data <= {in_data[23:19], in_data[15:10], in_data[7:3]};
                r_col_o    <= r_col;
                r_row_o    <= r_row;
                r_strip_o  <= r_strip;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign rgb_en     = r_rgb_en;
    assign rgb_data   = r_rgb_data;
    assign col_cnt    = r_col_o;
    assign row_cnt    = r_row_o;
    assign strip_cnt  = r_strip_o;
    assign strip_done = r_strip_done;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != StIdle);
    assign credit_err = r_credit_err;

endmodule

// File: tb/tb_fb_strip_writer.sv
// Directed bench for fb_strip_writer: a full-size instance for strip/credit/reset behaviour and a
// reduced-geometry instance for a complete 40-strip frame.
module tb_fb_strip_writer;

    localparam int unsigned COLS = 240;
    localparam int unsigned SP   = 1920;

    logic        wclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        rd_done_tgl = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_ready, rgb_en, strip_done, frame_done, busy, credit_err;
    logic [15:0] rgb_data;
    logic [7:0]  col_cnt, row_cnt;
    logic [5:0]  strip_cnt;

    logic        s_frame_start = 1'b0;
    logic        s_tgl = 1'b0;
    logic        s_in_ready, s_rgb_en, s_strip_done, s_frame_done, s_busy, s_credit_err;
    logic [15:0] s_rgb_data;
    logic [7:0]  s_col_cnt, s_row_cnt;
    logic [5:0]  s_strip_cnt;

    always #5 wclk = ~wclk;

    fb_strip_writer dut (
        .wclk(wclk), .reset_n(reset_n), .frame_start(frame_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .rd_done_tgl(rd_done_tgl), .rgb_en(rgb_en),
        .rgb_data(rgb_data), .col_cnt(col_cnt), .row_cnt(row_cnt), .strip_cnt(strip_cnt),
        .strip_done(strip_done), .frame_done(frame_done), .busy(busy), .credit_err(credit_err)
    );

    fb_strip_writer #(.COLS(4), .ROWS_PER_STRIP(2), .STRIPS(40), .NUM_BUFS(2)) dut_s (
        .wclk(wclk), .reset_n(reset_n), .frame_start(s_frame_start), .in_valid(1'b1),
        .in_data(24'h123456), .in_ready(s_in_ready), .rd_done_tgl(s_tgl), .rgb_en(s_rgb_en),
        .rgb_data(s_rgb_data), .col_cnt(s_col_cnt), .row_cnt(s_row_cnt),
        .strip_cnt(s_strip_cnt), .strip_done(s_strip_done), .frame_done(s_frame_done),
        .busy(s_busy), .credit_err(s_credit_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to565(input logic [23:0] d);
        return {d[23:19], d[15:10], d[7:3]};
    endfunction

    // Input driver: 0 = idle, 1 = constant pixel every cycle, 2 = random valid and data.
    int          drv_mode = 0;
    logic [23:0] c_data = 24'hF8FCF8;
    initial forever begin
        @(posedge wclk);
        #1;
        case (drv_mode)
            1: begin in_valid = 1'b1; in_data = c_data; end
            2: begin in_valid = 1'($urandom_range(0, 1)); in_data = 24'($urandom); end
            default: in_valid = 1'b0;
        endcase
    end

    // Scoreboard for the full-size instance.
    logic [23:0] q[$];
    int   k = 0, exp_strip = 0, en_cnt = 0, sd_cnt = 0, strip_len = 0;
    int   lat_err = 0, data_err = 0, pos_err = 0, sd_err = 0;
    logic acc_prev = 1'b0, prev_en = 1'b0;
    logic [15:0] last_data = '0;

    task automatic mon_clear();
        q.delete();
        k = 0; exp_strip = 0; en_cnt = 0; sd_cnt = 0; acc_prev = 1'b0; prev_en = 1'b0;
    endtask

    initial forever begin
        @(negedge wclk);
        if (rgb_en !== acc_prev) lat_err++;
        if (rgb_en === 1'b1) begin
            en_cnt++;
            last_data = rgb_data;
            if (q.size() == 0) data_err++;
            else if (rgb_data !== to565(q.pop_front())) data_err++;
            if (col_cnt !== 8'(k % COLS) || row_cnt !== 8'(k / COLS) ||
                strip_cnt !== 6'(exp_strip)) pos_err++;
            k++;
        end
        if (strip_done === 1'b1) begin
            sd_cnt++;
            if (rgb_en === 1'b1 || prev_en !== 1'b1 || k != SP) sd_err++;
            strip_len = k;
            k = 0;
            exp_strip++;
        end
        prev_en  = rgb_en;
        acc_prev = in_valid && in_ready;
        if (acc_prev) q.push_back(in_data);
    end

    // Reduced instance: read side returns a buffer promptly after each strip.
    int s_sd = 0, s_fd = 0, s_sd_at_fd = 0;
    logic [15:0] s_last = '0;
    initial forever begin
        @(negedge wclk);
        if (s_rgb_en === 1'b1) s_last = s_rgb_data;
        if (s_strip_done === 1'b1) begin
            s_sd++;
            s_tgl = ~s_tgl;
        end
        if (s_frame_done === 1'b1) begin
            s_fd++;
            s_sd_at_fd = s_sd;
        end
    end

    task automatic wait_strip(input int n, input int budget, input string tag);
        int c = 0;
        while (sd_cnt < n && c < budget) begin
            @(posedge wclk);
            c++;
        end
        check({tag, "_timeout"}, 32'(sd_cnt >= n), 32'd1);
        #2;
    endtask

    task automatic check_strip(input string tag, input logic [15:0] exp_last, input logic use_last);
        check({tag, "_len"}, strip_len, SP);
        check({tag, "_lat"}, lat_err, 0);
        check({tag, "_data"}, data_err, 0);
        check({tag, "_pos"}, pos_err, 0);
        check({tag, "_sdone"}, sd_err, 0);
        if (use_last) check({tag, "_word"}, last_data, exp_last);
    endtask

    task automatic toggle();
        @(posedge wclk);
        #1 rd_done_tgl = ~rd_done_tgl;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rgb_en"}, rgb_en, 0);
        check({tag, "_rgb_data"}, rgb_data, 0);
        check({tag, "_col"}, col_cnt, 0);
        check({tag, "_row"}, row_cnt, 0);
        check({tag, "_strip"}, strip_cnt, 0);
        check({tag, "_sdone"}, strip_done, 0);
        check({tag, "_fdone"}, frame_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cerr"}, credit_err, 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_credits"}, 32'(dut.r_credits), 2);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge wclk);
        #1 check_all_zero("reset");
        @(negedge wclk) reset_n = 1'b1;

        // Reduced instance: full frame, with a frame_start mid-frame that must be ignored.
        @(posedge wclk); #1 s_frame_start = 1'b1;
        @(posedge wclk); #1 s_frame_start = 1'b0;
        repeat (100) @(posedge wclk);
        #1 s_frame_start = 1'b1;
        @(posedge wclk); #1 s_frame_start = 1'b0;
        check("s_busy_mid", s_busy, 1);
        n = 0;
        while (s_fd < 1 && n < 3000) begin @(posedge wclk); n++; end
        repeat (50) @(posedge wclk);
        #1;
        check("s_strip_dones", s_sd, 40);
        check("s_dones_before_frame", s_sd_at_fd, 40);
        check("s_frame_dones", s_fd, 1);
        check("s_busy_end", s_busy, 0);
        check("s_credit_err", s_credit_err, 0);
        check("s_word", s_last, 16'h11AA);

        // Strip 0 with constant white, then strip 1 on the second credit.
        drv_mode = 1;
        @(posedge wclk); #1 frame_start = 1'b1;
        @(posedge wclk); #1 frame_start = 1'b0;
        wait_strip(1, 2500, "s0");
        check_strip("s0", 16'hFFFF, 1'b1);
        wait_strip(2, 2500, "s1");
        check_strip("s1", 16'hFFFF, 1'b1);

        // Out of credits: stalled with upstream held off.
        repeat (20) @(posedge wclk);
        #1;
        check("stall_ready", in_ready, 0);
        check("stall_busy", busy, 1);
        check("stall_words", en_cnt, 2 * SP);
        check("stall_credits", 32'(dut.r_credits), 0);

        // One return restarts streaming; strip 2 uses random bubbles and data.
        drv_mode = 2;
        toggle();
        n = 0;
        do begin @(negedge wclk); n++; end while (in_ready !== 1'b1 && n < 20);
        check("restart_latency", 32'(n <= 5), 1);
        wait_strip(3, 9000, "s2");
        check_strip("s2", 16'h0, 1'b0);

        // Two returns one cycle apart: the second coincides with the consume on entry.
        drv_mode = 1;
        c_data = 24'h123456;
        toggle();
        toggle();
        repeat (3) @(posedge wclk);
        #1;
        check("net0_ready", in_ready, 1);
        check("net0_credits", 32'(dut.r_credits), 1);
        toggle();
        repeat (5) @(posedge wclk);
        #1;
        check("fill_credits", 32'(dut.r_credits), 2);
        check("fill_cerr", credit_err, 0);
        toggle();
        repeat (5) @(posedge wclk);
        #1;
        check("over_credits", 32'(dut.r_credits), 2);
        check("over_cerr", credit_err, 1);

        // Reset in the middle of strip 3.
        n = 0;
        while (k < 1000 && n < 3000) begin @(posedge wclk); n++; end
        check("s3_reach_1000", 32'(k >= 1000), 1);
        check("s3_partial_pos", pos_err, 0);
        check("s3_partial_strip", 32'(exp_strip), 3);
        #1 reset_n = 1'b0;
        mon_clear();
        #1 check_all_zero("midreset");
        repeat (3) @(posedge wclk);
        @(negedge wclk) reset_n = 1'b1;

        @(posedge wclk); #1 frame_start = 1'b1;
        @(posedge wclk); #1 frame_start = 1'b0;
        wait_strip(1, 2500, "new_s0");
        check_strip("new_s0", 16'h11AA, 1'b1);

        drv_mode = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
